// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front-end: owns the fetch PC, issues one word read at a time
// to a variable-latency memory and queues returned words with their PCs for decode.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_data,
    output logic [31:0]              inst_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             LW   = PW + 1;
    localparam logic [LW-1:0]  FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   drop_addr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [LW-1:0] level_nxt;
    logic [31:0]   redirect_word;

    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    // A redirect kills both the returning word and any decode-side consumption.
    assign push = (state == REQ) && mem_ack && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    always_comb begin
        level_nxt = level;
        if (redirect)
            level_nxt = '0;
        else if (push && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_word;
                        state    <= REQ;
                    end else if (level < FULL) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_word;
                        state    <= mem_ack ? REQ : DROP;
                    end else if (mem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= (level_nxt < FULL) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    // The stale read must still be retired before a new one is issued.
                    if (redirect)
                        fetch_pc <= redirect_word;
                    if (mem_ack)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address of the read being abandoned; only meaningful while in DROP.
    always_ff @(posedge clock) begin
        if (state == REQ && redirect && !mem_ack)
            drop_addr <= fetch_pc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign mem_req    = (state == REQ) || (state == DROP);
    assign mem_addr   = (state == DROP) ? drop_addr : fetch_pc;
    assign inst_valid = (level != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'd0;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with a simple latency-programmable memory model.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  level;

    int checks;
    int errors;
    int wait_cnt;
    int lat;
    int ack_cnt;
    bit rand_ack;
    logic [31:0] exp_pc;

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .level       (level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        bit go;
        if (rand_ack)
            go = ($urandom_range(0, 1) == 1);
        else
            go = (wait_cnt >= lat);
        mem_ack   = mem_req && go;
        mem_rdata = mem_addr ^ 32'hA5A5_0000;
    endtask

    // One full cycle: from a falling edge, through the rising edge, to the next falling edge.
    task automatic tick();
        logic pr;
        logic pa;
        pr = mem_req;
        pa = mem_ack;
        @(posedge clock);
        if (pr && pa) begin
            wait_cnt = 0;
            ack_cnt++;
        end else if (pr) begin
            wait_cnt++;
        end
        @(negedge clock);
        drive_mem();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        mem_ack     = 1'b0;
        wait_cnt    = 0;
        ack_cnt     = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drive_mem();
    endtask

    initial begin
        clock     = 1'b0;
        checks    = 0;
        errors    = 0;
        lat       = 0;
        rand_ack  = 1'b0;
        mem_rdata = 32'd0;
        exp_pc    = 32'd0;

        // Reset state
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data",  inst_data, 32'd0);
        chk("rst_pc",    inst_pc, 32'd0);

        // Zero-wait streaming, one instruction per cycle
        do_reset();
        lat = 0; inst_ready = 1'b1;
        tick();
        chk("t1_req0",  32'(mem_req), 32'd1);
        chk("t1_addr0", mem_addr, 32'd0);
        chk("t1_nv",    32'(inst_valid), 32'd0);
        tick();
        chk("t1_level", 32'(level), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("t1_valid", 32'(inst_valid), 32'd1);
            chk("t1_pc",    inst_pc, 32'(4 * k));
            chk("t1_data",  inst_data, 32'(4 * k) ^ 32'hA5A5_0000);
            chk("t1_addr",  mem_addr, 32'(4 * k + 4));
            tick();
        end

        // Fill to DEPTH with decode stalled, then single pop refill
        do_reset();
        lat = 0; inst_ready = 1'b0;
        repeat (5) tick();
        chk("t2_acks",  ack_cnt, 32'd4);
        chk("t2_level", 32'(level), 32'd4);
        chk("t2_req",   32'(mem_req), 32'd0);
        chk("t2_head",  inst_pc, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t2_lvl3",  32'(level), 32'd3);
        chk("t2_head4", inst_pc, 32'd4);
        tick();
        chk("t2_req1",  32'(mem_req), 32'd1);
        chk("t2_addr",  mem_addr, 32'h10);
        tick();
        chk("t2_lvl4",  32'(level), 32'd4);
        chk("t2_req0",  32'(mem_req), 32'd0);
        chk("t2_acks5", ack_cnt, 32'd5);

        // Push and pop together at DEPTH-1
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6_lvl3a", 32'(level), 32'd3);
        tick();
        chk("t6_req",   32'(mem_req), 32'd1);
        chk("t6_addr",  mem_addr, 32'h14);
        inst_ready = 1'b1;
        tick();
        chk("t6_lvl3b", 32'(level), 32'd3);
        chk("t6_headC", inst_pc, 32'h0C);
        chk("t6_dataC", inst_data, 32'hA5A5_000C);
        tick();
        chk("t6_lvl3c", 32'(level), 32'd3);
        chk("t6_head10", inst_pc, 32'h10);
        inst_ready = 1'b0;
        tick();
        chk("t6_lvl4",  32'(level), 32'd4);
        chk("t6_idle",  32'(mem_req), 32'd0);

        // Redirect during a slow read: stale read is retired and discarded
        do_reset();
        lat = 2; inst_ready = 1'b0;
        repeat (7) tick();
        chk("t3_lvl2",  32'(level), 32'd2);
        chk("t3_addr8", mem_addr, 32'h08);
        chk("t3_wait",  32'(mem_ack), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("t3_hold1", mem_addr, 32'h08);
        chk("t3_req",   32'(mem_req), 32'd1);
        chk("t3_flush", 32'(level), 32'd0);
        chk("t3_nv",    32'(inst_valid), 32'd0);
        tick();
        chk("t3_hold2", mem_addr, 32'h08);
        chk("t3_ack",   32'(mem_ack), 32'd1);
        tick();
        chk("t3_new",   mem_addr, 32'h100);
        chk("t3_nopush", 32'(level), 32'd0);
        repeat (3) tick();
        chk("t3_valid", 32'(inst_valid), 32'd1);
        chk("t3_pc",    inst_pc, 32'h100);
        chk("t3_data",  inst_data, 32'hA5A5_0100);

        // Redirect coincident with an ack and a pop
        do_reset();
        lat = 0; inst_ready = 1'b0;
        repeat (3) tick();
        chk("t4_lvl2",  32'(level), 32'd2);
        chk("t4_ack",   32'(mem_ack), 32'd1);
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        inst_ready = 1'b0; redirect = 1'b0;
        chk("t4_lvl0",  32'(level), 32'd0);
        chk("t4_nv",    32'(inst_valid), 32'd0);
        chk("t4_data0", inst_data, 32'd0);
        chk("t4_addr",  mem_addr, 32'h200);
        tick();
        chk("t4_pc",    inst_pc, 32'h200);
        chk("t4_data",  inst_data, 32'hA5A5_0200);

        // Asynchronous reset with a request pending and level 3
        do_reset();
        lat = 0; inst_ready = 1'b0;
        repeat (4) tick();
        chk("t5_lvl3",  32'(level), 32'd3);
        chk("t5_req1",  32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_req0",  32'(mem_req), 32'd0);
        chk("t5_nv",    32'(inst_valid), 32'd0);
        chk("t5_lvl0",  32'(level), 32'd0);
        chk("t5_addr",  mem_addr, 32'd0);
        #1;
        reset = 1'b0;
        wait_cnt = 0;
        drive_mem();
        tick();
        chk("t5_restart", 32'(mem_req), 32'd1);
        chk("t5_raddr",   mem_addr, 32'd0);

        // Random ready/ack: occupancy bound and in-order delivery
        do_reset();
        rand_ack = 1'b1;
        drive_mem();
        exp_pc = 32'd0;
        for (int i = 0; i < 300; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            chk("rnd_bound", 32'(level <= 3'(DEPTH)), 32'd1);
            chk("rnd_valid", 32'(inst_valid), 32'(level != 3'd0));
            if (inst_valid && inst_ready) begin
                chk("rnd_pc",   inst_pc, exp_pc);
                chk("rnd_data", inst_data, exp_pc ^ 32'hA5A5_0000);
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        rand_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Instruction fetch front-end for the MIPS core. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small prefetch FIFO and presented to the decode side with a valid/ready handshake. A redirect input (branch taken) flushes the buffer and restarts fetch at a new PC, discarding any in-flight read.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
mem_req  out  1  read request to instruction memory.
mem_addr  out  32  word address of the request; bits [1:0] always 0.
mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
mem_rdata  in  32  instruction word returned.
inst_valid  out  1  FIFO head holds a valid instruction.
inst_ready  in  1  decode consumes the head this cycle.
inst_data  out  32  head instruction; 0 when empty.
inst_pc  out  32  PC of the head instruction; 0 when empty.
redirect  in  1  flush and restart fetch.
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0 to DEPTH.

Behaviour:
- Reset values: state IDLE, fetch_pc=RESET_PC, FIFO empty, level=0, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
- Memory handshake:
  - At most one outstanding read.
  - A transaction completes in a cycle with mem_req&&mem_ack.
  - While mem_req=1 and no ack, mem_addr stays stable.
  - A new request may be issued in the cycle right after an ack (back-to-back).
- State machine (mem_req = state is REQ or DROP; mem_addr = fetch_pc in REQ and the latched in-flight address in DROP):
  - IDLE: if level<DEPTH, go to REQ.
  - REQ, ack and no redirect: push {fetch_pc, mem_rdata}, then fetch_pc += 4 (wraps mod 2^32). Stay in REQ if the post-push/pop level is below DEPTH, else go to IDLE.
  - REQ, redirect and no ack: latch the in-flight address, set fetch_pc = redirect_pc, go to DROP.
  - REQ, redirect and ack together: discard the data, set fetch_pc = redirect_pc, go to REQ.
  - DROP: hold mem_req and the latched address. On ack, discard the data and go to REQ. A further redirect while in DROP only updates fetch_pc.
- Issue rule: a request is issued only when level<DEPTH. Because only one read is outstanding and level cannot rise during it, a slot is always free when the ack arrives. A push into a full FIFO must never occur.
- FIFO:
  - Push on accepted ack; pop when inst_valid&&inst_ready.
  - Push and pop in the same cycle leave level unchanged.
  - inst_valid = (level!=0); the head is registered, so a pushed word is visible the cycle after its ack.
  - Head fields read 0 when empty.
- Redirect has highest priority (below reset):
  - Clears the FIFO (level=0 next cycle).
  - Ignores a same-cycle pop and a same-cycle push.
  - inst_valid=0 the cycle after redirect.
- Latency and throughput:
  - Reset deassert: mem_req=1 with RESET_PC at the first clock edge.
  - Zero-wait memory: first inst_valid two edges after reset release; sustained 1 instruction/cycle while inst_ready=1.
  - Redirect with zero-wait memory: new PC on mem_addr in the cycle after redirect; first new instruction valid one cycle later.
- Reset mid-operation (asynchronous): all outputs return to reset values immediately, and any in-flight read is abandoned. The memory side must tolerate a dropped request.

Test Plan:
1. Reset, then zero-wait memory returning mem_rdata=addr^32'hA5A5_0000, inst_ready=1 -> mem_addr 0,4,8,... on consecutive cycles; inst_pc/inst_data stream 0/A5A5_0000, 4/A5A5_0004, ... one per cycle.
2. inst_ready=0, zero-wait memory, DEPTH=4 -> exactly 4 acks (addrs 0..C), level=4, mem_req=0. Then one inst_ready pulse -> head PC 0 leaves, one request at addr 0x10 issues, level returns to 4.
3. Memory with 3-cycle ack latency; redirect to 0x100 in the first wait cycle of the read of 0x8 -> mem_addr holds 0x8 until its ack and that data is not pushed; next mem_addr=0x100; first inst_pc after the flush is 0x100.
4. Redirect to 0x203 in the same cycle as an ack, with level=2 and inst_ready=1 -> level=0 and inst_valid=0 next cycle; next mem_addr=0x200.
5. Assert reset during a pending request with level=3 -> mem_req, inst_valid and level drop to 0 without a clock edge; after release, fetch restarts at RESET_PC.
6. level=DEPTH-1 with push and pop in the same cycle -> level stays DEPTH-1, order preserved, no overflow; level never exceeds DEPTH in any random ready/ack run.
